// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its consumers.
// Holds the FSM state encoding, the jump select encoding shared with
// control_unit, the IF/ID payload layout and the instruction field positions.
package fetch_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_HI  = 31;
  localparam int unsigned OPC_LO  = 26;
  localparam int unsigned FUNC_HI = 5;
  localparam int unsigned FUNC_LO = 0;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_J    = 2'b01;
  localparam logic [1:0] JMP_JR   = 2'b10;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } fetch_state_e;

  // IF/ID payload; the skid buffer uses the same layout.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus8;
  } if_id_t;

endpackage

// File: rtl/fetch_target_calc.sv
// Redirect decode and target computation for the instruction held in IF/ID.
// Ports:
//   if_id_instr, if_id_pc  - instruction in IF/ID and its PC
//   jump                   - 00 none, 01 j/jal, 10 jr, 11 treated as none
//   jr_target              - rs value for jr (low two bits ignored)
//   branch_taken           - beq/bne comparator result
//   redirect               - a jump or taken branch is requested (unqualified)
//   target                 - next PC; jump has priority over branch
module fetch_target_calc
  import fetch_stage_pkg::*;
(
  input  logic [XLEN-1:0] if_id_instr,
  input  logic [XLEN-1:0] if_id_pc,
  input  logic [1:0]      jump,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] jr_target,
  output logic            redirect,
  output logic [XLEN-1:0] target
);

  logic [1:0]      jsel;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_off;
  logic            unused_bits;

  // Fold the reserved encoding onto "no jump".
  assign jsel     = ((jump == JMP_J) || (jump == JMP_JR)) ? jump : JMP_NONE;
  assign pc_plus4 = if_id_pc + XLEN'(4);
  assign br_off   = {{(XLEN-18){if_id_instr[15]}}, if_id_instr[15:0], 2'b00};
  assign redirect = (jsel != JMP_NONE) | branch_taken;

  always_comb begin
    target = pc_plus4 + br_off;
    case (jsel)
      JMP_J:   target = {pc_plus4[XLEN-1:28], if_id_instr[25:0], 2'b00};
      JMP_JR:  target = {jr_target[XLEN-1:2], 2'b00};
      default: ;
    endcase
  end

  assign unused_bits = ^{if_id_instr[XLEN-1:26], jr_target[1:0]};

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   imem_req/imem_addr          - fetch request, address held until imem_ack
//   imem_ack/imem_rdata         - completion and instruction word
//   stall                       - ID hazard hold, freezes IF/ID
//   jump/jr_target/branch_taken - redirect controls from ID
//   if_id_*                     - registered instruction, PC, PC+8 and valid
//   opcode/func                 - instruction fields, zero when IF/ID is empty
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  jump,
  input  logic [31:0] jr_target,
  input  logic        branch_taken,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus8,
  output logic [5:0]  opcode,
  output logic [5:0]  func
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_d;
  logic            req_d;
  logic            valid_d;
  if_id_t          if_id_q, if_id_d;
  if_id_t          skid_q, skid_d;
  if_id_t          fetched;
  logic            tgt_redirect;
  logic [XLEN-1:0] target;
  logic            redirect;

  fetch_target_calc u_target (
    .if_id_instr  (if_id_q.instr),
    .if_id_pc     (if_id_q.pc),
    .jump         (jump),
    .branch_taken (branch_taken),
    .jr_target    (jr_target),
    .redirect     (tgt_redirect),
    .target       (target)
  );

  // Stall gates redirects so jr never consumes a stale rs.
  assign redirect = if_id_valid & ~stall & tgt_redirect;

  // Next-state, PC and IF/ID update.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    valid_d          = if_id_valid;
    if_id_d          = if_id_q;
    skid_d           = skid_q;
    fetched.instr    = imem_rdata;
    fetched.pc       = pc_q;
    fetched.pc_plus8 = pc_q + XLEN'(8);

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = target;
          if (!imem_ack) state_d = S_DRAIN;
        end else if (imem_ack && stall) begin
          skid_d  = fetched;
          pc_d    = pc_q + XLEN'(4);
          state_d = S_HOLD;
        end else if (imem_ack) begin
          if_id_d = fetched;
          valid_d = 1'b1;
          pc_d    = pc_q + XLEN'(4);
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = target;
          skid_d  = '0;
          state_d = S_FETCH;
        end else if (!stall) begin
          if_id_d = skid_q;
          valid_d = 1'b1;
          skid_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = target;
        end
        if (imem_ack) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // The squashed request keeps its address until memory acknowledges it.
    addr_d = (state_d == S_DRAIN) ? imem_addr : pc_d;
    req_d  = (state_d == S_FETCH) || (state_d == S_DRAIN);
  end

  // State, PC, request and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      imem_addr   <= RESET_PC;
      imem_req    <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_q     <= '{instr: NOP_INSTR, pc: '0, pc_plus8: '0};
      skid_q      <= '0;
      opcode      <= '0;
      func        <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_addr   <= addr_d;
      imem_req    <= req_d;
      if_id_valid <= valid_d;
      if_id_q     <= if_id_d;
      skid_q      <= skid_d;
      opcode      <= valid_d ? if_id_d.instr[OPC_HI:OPC_LO]   : 6'(0);
      func        <= valid_d ? if_id_d.instr[FUNC_HI:FUNC_LO] : 6'(0);
    end
  end

  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus8 = if_id_q.pc_plus8;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by randomized
// traffic checked against a program-order reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic [1:0]  jump = 2'b00;
  logic [31:0] jr_target = '0;
  logic        branch_taken = 1'b0;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus8;
  logic [5:0]  opcode;
  logic [5:0]  func;

  int          total = 0;
  int          bad = 0;
  int          waited = 0;
  int          cur_delay = 0;
  bit          rand_mem = 1'b0;
  logic [31:0] key = '0;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .jump           (jump),
    .jr_target      (jr_target),
    .branch_taken   (branch_taken),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus8 (if_id_pc_plus8),
    .opcode         (opcode),
    .func           (func)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instruction memory image.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h1000_FFFF;
    if (a == 32'h1000_0020) return 32'h0800_0040;
    return a ^ key;
  endfunction

  // Architectural next PC after an instruction leaves IF/ID.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                           input logic [1:0] jmp, input logic br,
                                           input logic [31:0] jrt);
    int off;
    if (jmp == 2'd1) return ((pc + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (jmp == 2'd2) return jrt & ~32'h3;
    if (br) begin
      off = $signed(ins[15:0]);
      return pc + 32'd4 + 32'(off * 4);
    end
    return pc + 32'd4;
  endfunction

  // Advance to the next falling edge and play the memory side.
  task automatic cycle();
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom();
    if (imem_req) begin
      if (waited >= cur_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = memf(imem_addr);
        waited     = 0;
        if (rand_mem) cur_delay = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end else begin
        waited++;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0; jump = 2'b00; branch_taken = 1'b0; jr_target = '0;
    imem_ack = 1'b0; imem_rdata = '0; waited = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0]  exp_pc;
  logic [96:0]  snap;
  logic         p_req, p_ack, p_stall;
  logic [31:0]  p_addr;
  int           idle, consumed;

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_ifid", {if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus8}, 97'h0);
    check_eq("rst_fields", {opcode, func}, 12'h0);

    // Zero-wait stream, then a 3-cycle ack delay at 0x10
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_eq("zw_req", imem_req, 1);
      check_eq("zw_addr", imem_addr, 32'(4 * k));
      if (k > 0) begin
        check_eq("zw_valid", if_id_valid, 1);
        check_eq("zw_instr", if_id_instr, 32'(4 * (k - 1)));
        check_eq("zw_pc8", {if_id_pc, if_id_pc_plus8}, {32'(4 * (k - 1)), 32'(4 * (k - 1) + 8)});
      end
      if (k == 3) cur_delay = 3;
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("wait_addr", {imem_req, imem_addr}, {1'b1, 32'h10});
      check_eq("wait_bubble", if_id_valid, 0);
    end
    cur_delay = 0;
    cycle();
    check_eq("wait_instr", {if_id_valid, if_id_instr, if_id_pc}, {1'b1, 32'h10, 32'h10});

    // Stall with skid buffer
    do_reset();
    repeat (3) cycle();
    check_eq("stall_pre", if_id_instr, 32'h4);
    stall = 1'b1;
    cycle();
    check_eq("hold_req1", imem_req, 0);
    check_eq("hold_ifid1", {if_id_valid, if_id_instr, if_id_pc}, {1'b1, 32'h4, 32'h4});
    cycle();
    check_eq("hold_req2", imem_req, 0);
    check_eq("hold_ifid2", {if_id_valid, if_id_instr, if_id_pc}, {1'b1, 32'h4, 32'h4});
    stall = 1'b0;
    cycle();
    check_eq("skid_word", {if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus8}, {1'b1, 32'h8, 32'h8, 32'h10});
    cycle();
    check_eq("skid_next", {if_id_valid, if_id_instr}, {1'b1, 32'hC});

    // jr, beq, jump-over-branch priority, j
    do_reset();
    cycle();
    cycle();
    check_eq("jr_pre", {if_id_valid, if_id_pc}, {1'b1, 32'h0});
    jump = 2'b10; jr_target = 32'h203;
    cycle();
    jump = 2'b00;
    check_eq("jr_squash", if_id_valid, 0);
    check_eq("jr_addr", imem_addr, 32'h200);
    cycle();
    check_eq("jr_land", {if_id_valid, if_id_pc, if_id_instr}, {1'b1, 32'h200, 32'h200});
    jump = 2'b10; jr_target = 32'h43;
    cycle();
    jump = 2'b00;
    check_eq("jr2_addr", imem_addr, 32'h40);
    cycle();
    check_eq("beq_pre", {if_id_valid, if_id_pc, if_id_instr}, {1'b1, 32'h40, 32'h1000_FFFF});
    branch_taken = 1'b1;
    cycle();
    branch_taken = 1'b0;
    check_eq("beq_squash", if_id_valid, 0);
    check_eq("beq_addr", imem_addr, 32'h40);
    cycle();
    check_eq("beq_land", {if_id_valid, if_id_pc}, {1'b1, 32'h40});
    jump = 2'b10; jr_target = 32'h1000_0023; branch_taken = 1'b1;
    cycle();
    jump = 2'b00; branch_taken = 1'b0;
    check_eq("prio_addr", imem_addr, 32'h1000_0020);
    cycle();
    check_eq("j_pre", {if_id_valid, if_id_pc, if_id_instr}, {1'b1, 32'h1000_0020, 32'h0800_0040});
    check_eq("j_fields", {opcode, func}, {6'd2, 6'd0});
    jump = 2'b01;
    cycle();
    jump = 2'b00;
    check_eq("j_squash", if_id_valid, 0);
    check_eq("j_addr", imem_addr, 32'h1000_0100);
    cycle();
    check_eq("j_land", {if_id_valid, if_id_pc, if_id_pc_plus8}, {1'b1, 32'h1000_0100, 32'h1000_0108});

    // Redirect while a request is outstanding
    do_reset();
    cycle();
    cur_delay = 2;
    cycle();
    check_eq("drain_pre", {if_id_valid, if_id_pc, imem_addr}, {1'b1, 32'h0, 32'h4});
    jump = 2'b10; jr_target = 32'h300;
    cycle();
    jump = 2'b00;
    check_eq("drain_hold1", {imem_req, imem_addr, if_id_valid}, {1'b1, 32'h4, 1'b0});
    cycle();
    check_eq("drain_hold2", {imem_req, imem_addr, if_id_valid}, {1'b1, 32'h4, 1'b0});
    cur_delay = 0;
    cycle();
    check_eq("drain_drop", if_id_valid, 0);
    check_eq("drain_target", {imem_req, imem_addr}, {1'b1, 32'h300});
    cycle();
    check_eq("drain_land", {if_id_valid, if_id_pc, if_id_instr}, {1'b1, 32'h300, 32'h300});

    // Reset in the middle of a wait, then a late ack
    do_reset();
    cur_delay = 5;
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst", {imem_req, imem_addr, if_id_valid, opcode, func}, 45'h0);
    do_reset();
    cur_delay = 0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cycle();
    check_eq("late_ack_valid", if_id_valid, 0);
    check_eq("late_ack_addr", imem_addr, 32'h0);
    cycle();
    check_eq("late_ack_instr", {if_id_valid, if_id_instr}, {1'b1, 32'h0});

    // Randomized traffic against the program-order model
    key = $urandom();
    do_reset();
    rand_mem = 1'b1;
    exp_pc = 32'h0; idle = 0; consumed = 0;
    p_req = 1'b0; p_ack = 1'b0; p_stall = 1'b0; p_addr = '0; snap = '0;
    for (int n = 0; n < 4000; n++) begin
      cycle();
      if (p_stall)
        check_eq("r_stall_hold", {if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus8}, snap);
      if (p_req && !p_ack)
        check_eq("r_addr_stable", {imem_req, imem_addr}, {1'b1, p_addr});
      if (if_id_valid)
        check_eq("r_fields", {opcode, func, if_id_pc_plus8},
                 {if_id_instr[31:26], if_id_instr[5:0], if_id_pc + 32'd8});
      else
        check_eq("r_fields_zero", {opcode, func}, 12'h0);
      stall     = ($urandom_range(0, 3) == 0);
      jr_target = $urandom();
      if (if_id_valid && !stall) begin
        check_eq("r_pc", if_id_pc, exp_pc);
        check_eq("r_instr", if_id_instr, memf(exp_pc));
        if ($urandom_range(0, 3) == 0) begin
          jump         = 2'($urandom_range(0, 3));
          branch_taken = 1'($urandom_range(0, 1));
        end else begin
          jump         = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
          branch_taken = 1'b0;
        end
        exp_pc = ref_next(exp_pc, memf(exp_pc), jump, branch_taken, jr_target);
        idle = 0;
        consumed++;
      end else begin
        jump         = 2'($urandom_range(0, 3));
        branch_taken = 1'($urandom_range(0, 1));
        idle++;
        if (idle > 40) begin
          check_eq("r_progress", 128'(idle), 128'(0));
          break;
        end
      end
      p_stall = stall;
      snap    = {if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus8};
      p_req   = imem_req;
      p_ack   = imem_ack;
      p_addr  = imem_addr;
    end
    check_eq("r_consumed", (consumed > 200), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
